btn_enable_conditioner: RTL and testbench

- Upstream stage of the 4-bit up_counter.
- Conditions a raw, bouncy, asynchronous push-button into a clean enable/direction level that drives the counter's x input.
- Synchronises the button, debounces it with a 4-state FSM, and emits one-cycle rise/fall pulses.
- In toggle mode each accepted press flips x_en.

---
 rtl/btn_enable_conditioner.sv | 76 +++++++
 tb/tb_btn_enable_conditioner.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/btn_enable_conditioner.sv
// btn_enable_conditioner: synchronises and debounces a raw push-button into a level, edge pulses and a counter enable
module btn_enable_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  input  logic mode,
  output logic btn_level,
  output logic btn_rise,
  output logic btn_fall,
  output logic x_en
);
  typedef enum logic [1:0] {IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW} state_t;
  state_t state, state_nx;
  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic btn_s, done, level_nx, rise_nx, fall_nx;
  assign btn_s = sync[SYNC_STAGES-1];
  assign done  = cnt == CNT_W'(DEBOUNCE_CYCLES - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sync      <= '0;
      state     <= IDLE_LOW;
      cnt       <= '0;
      btn_level <= 1'b0;
      btn_rise  <= 1'b0;
      btn_fall  <= 1'b0;
      x_en      <= 1'b0;
    end else begin
      sync      <= {sync[SYNC_STAGES-2:0], btn_raw};
      state     <= state_nx;
      cnt       <= cnt_nx;
      btn_level <= level_nx;
      btn_rise  <= rise_nx;
      btn_fall  <= fall_nx;
      x_en      <= mode ? x_en ^ rise_nx : level_nx;
    end
  // cnt counts consecutive samples at the new level; any disagreeing sample drops back to idle
  always_comb begin
    state_nx = state;
    cnt_nx   = '0;
    level_nx = btn_level;
    rise_nx  = 1'b0;
    fall_nx  = 1'b0;
    case (state)
      IDLE_LOW:
        if (btn_s) begin
          state_nx = WAIT_HIGH;
          cnt_nx   = CNT_W'(1);
        end
      WAIT_HIGH:
        if (!btn_s) state_nx = IDLE_LOW;
        else if (done) begin
          state_nx = IDLE_HIGH;
          level_nx = 1'b1;
          rise_nx  = 1'b1;
        end else cnt_nx = cnt + CNT_W'(1);
      IDLE_HIGH:
        if (!btn_s) begin
          state_nx = WAIT_LOW;
          cnt_nx   = CNT_W'(1);
        end
      WAIT_LOW:
        if (btn_s) state_nx = IDLE_HIGH;
        else if (done) begin
          state_nx = IDLE_LOW;
          level_nx = 1'b0;
          fall_nx  = 1'b1;
        end else cnt_nx = cnt + CNT_W'(1);
      default: state_nx = IDLE_LOW;
    endcase
  end
endmodule

// File: tb/tb_btn_enable_conditioner.sv
// tb_btn_enable_conditioner: directed stimulus, run-length reference model checked every cycle plus literal checkpoints
module tb_btn_enable_conditioner;
  localparam int SS = 2;
  localparam int DB = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_raw = 1'b0;
  logic mode = 1'b0;
  logic btn_level, btn_rise, btn_fall, x_en;
  int total = 0;
  int bad = 0;
  btn_enable_conditioner #(.SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw), .mode(mode),
    .btn_level(btn_level), .btn_rise(btn_rise), .btn_fall(btn_fall), .x_en(x_en)
  );
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0b exp=%0b at %0t", nm, got, exp, $time);
    end
  endtask
  // model: a sample delayed by SS edges reaches the debouncer; DB consecutive disagreeing samples flip the level
  logic mq [SS];
  logic ms, m_lvl, m_rise, m_fall, m_x;
  int run;
  always @(posedge clk or negedge reset)
    if (!reset) begin
      for (int i = 0; i < SS; i++) mq[i] = 1'b0;
      run = 0; m_lvl = 0; m_rise = 0; m_fall = 0; m_x = 0;
    end else begin
      ms = mq[SS-1];
      for (int i = SS - 1; i > 0; i--) mq[i] = mq[i-1];
      mq[0] = btn_raw;
      m_rise = 0;
      m_fall = 0;
      run = (ms != m_lvl) ? run + 1 : 0;
      if (run == DB) begin
        m_lvl = ms; run = 0; m_rise = ms; m_fall = !ms;
      end
      m_x = mode ? m_x ^ m_rise : m_lvl;
    end
  always @(negedge clk) begin
    #1;
    check("model_level", btn_level, m_lvl);
    check("model_rise", btn_rise, m_rise);
    check("model_fall", btn_fall, m_fall);
    check("model_x_en", x_en, m_x);
    check("pulse_excl", btn_rise & btn_fall, 1'b0);
  end
  task automatic edge_walk(input logic v, input logic chk_x);
    btn_raw = v;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      check("walk_level", btn_level, (k >= 6) ? v : !v);
      check("walk_rise", btn_rise, v && k == 6);
      check("walk_fall", btn_fall, !v && k == 6);
      if (chk_x) check("walk_x_en", x_en, (k >= 6) ? v : !v);
    end
  endtask
  logic bpat [14] = '{1, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
  logic exp_x;
  initial begin
    #1 reset = 1'b0;
    btn_raw = 1'b1;
    mode = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_level", btn_level, 1'b0);
      check("rst_rise", btn_rise, 1'b0);
      check("rst_x_en", x_en, 1'b0);
    end
    reset = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      check("rel_level", btn_level, k >= 6);
      check("rel_rise", btn_rise, k == 6);
      check("rel_x_en", x_en, k >= 6);
    end
    mode = 1'b0;
    edge_walk(1'b0, 1'b1);
    repeat (3) @(negedge clk);
    edge_walk(1'b1, 1'b1);
    repeat (3) @(negedge clk);
    edge_walk(1'b0, 1'b1);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 14; i++) begin
      btn_raw = bpat[i];
      @(negedge clk);
      check("bounce_level", btn_level, 1'b0);
      check("bounce_rise", btn_rise, 1'b0);
      check("bounce_x_en", x_en, 1'b0);
    end
    mode = 1'b1;
    exp_x = 1'b0;
    for (int p = 0; p < 3; p++) begin
      btn_raw = 1'b1;
      repeat (10) @(negedge clk);
      exp_x = !exp_x;
      check("tog_press_x_en", x_en, exp_x);
      btn_raw = 1'b0;
      repeat (10) @(negedge clk);
      check("tog_release_x_en", x_en, exp_x);
    end
    btn_raw = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("mid_rise", btn_rise, 1'b0);
      check("mid_level", btn_level, 1'b0);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_rst_level", btn_level, 1'b0);
    check("mid_rst_x_en", x_en, 1'b0);
    reset = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check("mid_rel_rise", btn_rise, k == 6);
      check("mid_rel_level", btn_level, k == 6);
    end
    check("mid_rel_x_en", x_en, 1'b1);
    btn_raw = 1'b0;
    repeat (10) @(negedge clk);
    check("ms_released_level", btn_level, 1'b0);
    check("ms_held_x_en", x_en, 1'b1);
    mode = 1'b0;
    @(negedge clk);
    check("ms_to0_x_en", x_en, 1'b0);
    check("ms_to0_rise", btn_rise, 1'b0);
    check("ms_to0_fall", btn_fall, 1'b0);
    mode = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("ms_to1_x_en", x_en, 1'b0);
    end
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
